// File: rtl/nfc_atom_ca_latch_if.sv
// ============================================================================
// Module   : nfc_atom_ca_latch_if
// Brief    : Command-side request/response and NAND pin bundle for the
//            atomic CA latch generator.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface nfc_atom_ca_latch_if #(
    parameter int NumberOfWays = 4
);
    logic                    iStart;
    logic                    oReady;
    logic                    oLastStep;
    logic [NumberOfWays-1:0] iTargetWay;
    logic [15:0]             iNumOfData;
    logic                    iCASelect;
    logic [39:0]             iCAData;
    logic [NumberOfWays-1:0] oCE_n;
    logic                    oCLE;
    logic                    oALE;
    logic                    oWE_n;
    logic [7:0]              oDQ;
    logic                    oDQOE;

    modport master (
        output iStart, iTargetWay, iNumOfData, iCASelect, iCAData,
        input  oReady, oLastStep, oCE_n, oCLE, oALE, oWE_n, oDQ, oDQOE
    );

    modport slave (
        input  iStart, iTargetWay, iNumOfData, iCASelect, iCAData,
        output oReady, oLastStep, oCE_n, oCLE, oALE, oWE_n, oDQ, oDQOE
    );
endinterface

`default_nettype wire

// File: rtl/nfc_atom_ca_latch.sv
// ============================================================================
// Module   : nfc_atom_ca_latch
// Brief    : Drives the CLE/ALE/WE#/DQ pin sequence for 1-5 command or
//            address bytes; all pin outputs come straight from flops.
// Revision : 1.0
// ============================================================================
`default_nettype none

module nfc_atom_ca_latch #(
    parameter int NumberOfWays = 4,
    parameter int tCS_CYC      = 3,
    parameter int tWP_CYC      = 2,
    parameter int tWH_CYC      = 2,
    parameter int tCH_CYC      = 2
) (
    input  wire logic             iSystemClock,
    input  wire logic             iReset,
    nfc_atom_ca_latch_if.slave    bus
);

    localparam logic [3:0] CS_LD = 4'(tCS_CYC - 1);
    localparam logic [3:0] WP_LD = 4'(tWP_CYC - 1);
    localparam logic [3:0] WH_LD = 4'(tWH_CYC - 1);
    localparam logic [3:0] CH_LD = 4'(tCH_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_WE_LOW  = 3'd2,
        S_WE_HIGH = 3'd3,
        S_HOLD    = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t                  state, state_nxt;
    logic [3:0]              cnt, cnt_nxt;
    logic [2:0]              rem, rem_nxt;
    logic [39:0]             data, data_nxt;
    logic [NumberOfWays-1:0] way, way_nxt;
    logic                    casel, casel_nxt;
    logic                    has_bytes, has_bytes_nxt;

    logic [2:0]              num_clamped;
    logic                    active;
    logic [NumberOfWays-1:0] ce_nxt;
    logic                    cle_nxt, ale_nxt, we_nxt, dqoe_nxt, ready_nxt, last_nxt;
    logic [7:0]              dq_nxt;

    assign num_clamped = (bus.iNumOfData > 16'd5) ? 3'd5 : bus.iNumOfData[2:0];

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        rem_nxt       = rem;
        data_nxt      = data;
        way_nxt       = way;
        casel_nxt     = casel;
        has_bytes_nxt = has_bytes;

        case (state)
            S_IDLE: begin
                if (bus.iStart && bus.oReady) begin
                    state_nxt     = S_SETUP;
                    cnt_nxt       = CS_LD;
                    rem_nxt       = num_clamped;
                    has_bytes_nxt = (num_clamped != 3'd0);
                    data_nxt      = bus.iCAData;
                    way_nxt       = bus.iTargetWay;
                    casel_nxt     = bus.iCASelect;
                end
            end
            S_SETUP: begin
                if (cnt == 4'd0) begin
                    if (rem == 3'd0) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_WE_LOW;
                        cnt_nxt   = WP_LD;
                    end
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            S_WE_LOW: begin
                if (cnt == 4'd0) begin
                    state_nxt = S_WE_HIGH;
                    cnt_nxt   = WH_LD;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            S_WE_HIGH: begin
                if (cnt == 4'd0) begin
                    data_nxt = {data[31:0], 8'h00};
                    rem_nxt  = rem - 3'd1;
                    if (rem > 3'd1) begin
                        state_nxt = S_WE_LOW;
                        cnt_nxt   = WP_LD;
                    end else begin
                        state_nxt = S_HOLD;
                        cnt_nxt   = CH_LD;
                    end
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            S_HOLD: begin
                if (cnt == 4'd0) begin
                    state_nxt = S_DONE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        // Pins are registered from the next state so they line up with it.
        active    = (state_nxt == S_SETUP) || (state_nxt == S_WE_LOW) ||
                    (state_nxt == S_WE_HIGH) || (state_nxt == S_HOLD);
        ce_nxt    = active ? way_nxt : '1;
        cle_nxt   = active && has_bytes_nxt && casel_nxt;
        ale_nxt   = active && has_bytes_nxt && !casel_nxt;
        we_nxt    = (state_nxt != S_WE_LOW);
        dq_nxt    = active ? data_nxt[39:32] : 8'h00;
        dqoe_nxt  = active;
        ready_nxt = (state_nxt == S_IDLE);
        last_nxt  = (state_nxt == S_DONE);
    end

    always_ff @(posedge iSystemClock or posedge iReset) begin
        if (iReset) begin
            state         <= S_IDLE;
            cnt           <= 4'd0;
            rem           <= 3'd0;
            data          <= 40'd0;
            way           <= '1;
            casel         <= 1'b0;
            has_bytes     <= 1'b0;
            bus.oReady    <= 1'b1;
            bus.oLastStep <= 1'b0;
            bus.oCE_n     <= '1;
            bus.oCLE      <= 1'b0;
            bus.oALE      <= 1'b0;
            bus.oWE_n     <= 1'b1;
            bus.oDQ       <= 8'h00;
            bus.oDQOE     <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            rem           <= rem_nxt;
            data          <= data_nxt;
            way           <= way_nxt;
            casel         <= casel_nxt;
            has_bytes     <= has_bytes_nxt;
            bus.oReady    <= ready_nxt;
            bus.oLastStep <= last_nxt;
            bus.oCE_n     <= ce_nxt;
            bus.oCLE      <= cle_nxt;
            bus.oALE      <= ale_nxt;
            bus.oWE_n     <= we_nxt;
            bus.oDQ       <= dq_nxt;
            bus.oDQOE     <= dqoe_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_nfc_atom_ca_latch.sv
// ============================================================================
// Module   : tb_nfc_atom_ca_latch
// Brief    : Directed-vector bench for the atomic CA latch generator.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_nfc_atom_ca_latch;

    logic iSystemClock = 1'b0;
    logic iReset       = 1'b1;

    nfc_atom_ca_latch_if #(.NumberOfWays(4)) bus();

    nfc_atom_ca_latch #(
        .NumberOfWays(4), .tCS_CYC(3), .tWP_CYC(2), .tWH_CYC(2), .tCH_CYC(2)
    ) dut (
        .iSystemClock (iSystemClock),
        .iReset       (iReset),
        .bus          (bus.slave)
    );

    always #5 iSystemClock = ~iSystemClock;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Per-transaction observations; cycle k is the k-th cycle after the accept edge.
    logic [3:0] t_way;
    int         t_first_ce, t_ce_cnt, t_falls, t_fall1, t_welow;
    int         t_last_cyc, t_nlast, t_ready_cyc, t_viol;
    logic       t_cle, t_ale, t_prev_we, t_end_ready;
    logic [3:0] t_end_ce;
    logic [7:0] dq_log [0:7];

    task automatic clear_obs(input logic [3:0] way);
        t_way = way; t_first_ce = 0; t_ce_cnt = 0; t_falls = 0; t_fall1 = 0;
        t_welow = 0; t_last_cyc = 0; t_nlast = 0; t_ready_cyc = 0; t_viol = 0;
        t_cle = 1'b0; t_ale = 1'b0; t_prev_we = 1'b1;
        for (int i = 0; i < 8; i++) dq_log[i] = 8'h00;
    endtask

    task automatic sample(input int k);
        if (bus.oCE_n != 4'b1111 && t_first_ce == 0) t_first_ce = k;
        if (bus.oCE_n == t_way) t_ce_cnt++;
        if (bus.oCLE) t_cle = 1'b1;
        if (bus.oALE) t_ale = 1'b1;
        if (!bus.oWE_n) begin
            t_welow++;
            if (!(bus.oCE_n == t_way && (bus.oCLE ^ bus.oALE))) t_viol++;
        end
        if (t_prev_we && !bus.oWE_n) begin
            if (t_falls < 8) dq_log[t_falls] = bus.oDQ;
            t_falls++;
            if (t_falls == 1) t_fall1 = k;
        end
        t_prev_we = bus.oWE_n;
        if (bus.oLastStep) begin
            t_nlast++;
            if (t_last_cyc == 0) t_last_cyc = k;
        end
        if (bus.oReady && t_ready_cyc == 0) t_ready_cyc = k;
        t_end_ready = bus.oReady;
        t_end_ce    = bus.oCE_n;
    endtask

    // Accept happens at the first posedge after iStart rises; observe 'cycles' cycles.
    task automatic run_txn(input logic [3:0] way, input logic [15:0] num, input logic casel,
                           input logic [39:0] data, input logic hold, input int cycles);
        clear_obs(way);
        @(negedge iSystemClock);
        bus.iTargetWay = way; bus.iNumOfData = num; bus.iCASelect = casel;
        bus.iCAData = data; bus.iStart = 1'b1;
        @(posedge iSystemClock); #1;
        if (!hold) begin
            bus.iStart = 1'b0;
            bus.iCAData = 40'hDE_AD_BE_EF_00;
            bus.iTargetWay = 4'b0000;
            bus.iCASelect = ~casel;
        end
        for (int k = 1; k <= cycles; k++) begin
            sample(k);
            @(posedge iSystemClock); #1;
        end
    endtask

    initial begin
        bus.iStart = 1'b0; bus.iTargetWay = 4'b1111; bus.iNumOfData = 16'd0;
        bus.iCASelect = 1'b0; bus.iCAData = 40'd0;
        repeat (3) @(posedge iSystemClock);
        #1;
        check_val("rst_ready", bus.oReady, 1);
        check_val("rst_last",  bus.oLastStep, 0);
        check_val("rst_ce",    bus.oCE_n, 4'b1111);
        check_val("rst_we",    bus.oWE_n, 1);
        check_val("rst_clale", {bus.oCLE, bus.oALE, bus.oDQOE}, 3'b000);
        check_val("rst_dq",    bus.oDQ, 8'h00);
        @(negedge iSystemClock); iReset = 1'b0;
        repeat (2) @(posedge iSystemClock);

        // Reset command, one byte
        run_txn(4'b1110, 16'd1, 1'b1, 40'hFF_00000000, 1'b0, 12);
        check_val("c1_ce_first", t_first_ce, 1);
        check_val("c1_ce_cnt",   t_ce_cnt, 9);
        check_val("c1_cle_ale",  {t_cle, t_ale}, 2'b10);
        check_val("c1_falls",    t_falls, 1);
        check_val("c1_fall_cyc", t_fall1, 4);
        check_val("c1_welow",    t_welow, 2);
        check_val("c1_dq",       dq_log[0], 8'hFF);
        check_val("c1_last_cyc", t_last_cyc, 10);
        check_val("c1_nlast",    t_nlast, 1);
        check_val("c1_ready",    t_ready_cyc, 11);
        check_val("c1_safety",   t_viol, 0);

        // Five-byte address
        run_txn(4'b0111, 16'd5, 1'b0, 40'h11_22_33_44_55, 1'b0, 28);
        check_val("a5_cle_ale",  {t_cle, t_ale}, 2'b01);
        check_val("a5_falls",    t_falls, 5);
        check_val("a5_dq",       {dq_log[0], dq_log[1], dq_log[2], dq_log[3], dq_log[4]},
                  40'h11_22_33_44_55);
        check_val("a5_welow",    t_welow, 10);
        check_val("a5_last_cyc", t_last_cyc, 26);
        check_val("a5_ready",    t_ready_cyc, 27);
        check_val("a5_safety",   t_viol, 0);

        // Zero bytes
        run_txn(4'b1011, 16'd0, 1'b1, 40'hAB_00000000, 1'b0, 6);
        check_val("z_falls",     t_falls, 0);
        check_val("z_cle_ale",   {t_cle, t_ale}, 2'b00);
        check_val("z_last_cyc",  t_last_cyc, 4);
        check_val("z_nlast",     t_nlast, 1);
        check_val("z_ready",     t_ready_cyc, 5);

        // Count above five is clamped
        run_txn(4'b1101, 16'h0007, 1'b0, 40'h01_02_03_04_05, 1'b0, 28);
        check_val("c7_falls",    t_falls, 5);
        check_val("c7_dq_last",  dq_log[4], 8'h05);
        check_val("c7_last_cyc", t_last_cyc, 26);

        // iStart held high: one completion, re-accept only when oReady is high
        run_txn(4'b1101, 16'd1, 1'b1, 40'h30_00000000, 1'b1, 12);
        check_val("h_nlast",     t_nlast, 1);
        check_val("h_last_cyc",  t_last_cyc, 10);
        check_val("h_ready",     t_ready_cyc, 11);
        check_val("h_reacc_rdy", t_end_ready, 0);
        check_val("h_reacc_ce",  t_end_ce, 4'b1101);
        bus.iStart = 1'b0;
        clear_obs(4'b1101);
        t_prev_we = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            sample(k);
            @(posedge iSystemClock); #1;
        end
        check_val("h_2nd_nlast", t_nlast, 1);
        check_val("h_2nd_idle",  bus.oReady, 1);

        // Reset asserted during the third byte
        clear_obs(4'b0111);
        @(negedge iSystemClock);
        bus.iTargetWay = 4'b0111; bus.iNumOfData = 16'd5; bus.iCASelect = 1'b0;
        bus.iCAData = 40'h11_22_33_44_55; bus.iStart = 1'b1;
        @(posedge iSystemClock); #1;
        bus.iStart = 1'b0;
        for (int k = 1; k <= 40 && t_falls < 3; k++) begin
            sample(k);
            if (t_falls < 3) begin
                @(posedge iSystemClock); #1;
            end
        end
        check_val("r_reached",   t_falls, 3);
        #2 iReset = 1'b1;
        #1;
        check_val("r_ce",        bus.oCE_n, 4'b1111);
        check_val("r_we",        bus.oWE_n, 1);
        check_val("r_ready",     bus.oReady, 1);
        check_val("r_pins",      {bus.oCLE, bus.oALE, bus.oDQOE, bus.oLastStep}, 4'b0000);
        clear_obs(4'b0111);
        repeat (2) begin
            @(posedge iSystemClock); #1; sample(1);
        end
        @(negedge iSystemClock); iReset = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(posedge iSystemClock); #1; sample(k);
        end
        check_val("r_no_last",   t_nlast, 0);

        // Normal two-byte command after reset release
        run_txn(4'b1011, 16'd2, 1'b1, 40'hA5_5A_000000, 1'b0, 16);
        check_val("p_falls",     t_falls, 2);
        check_val("p_dq",        {dq_log[0], dq_log[1]}, 16'hA55A);
        check_val("p_last_cyc",  t_last_cyc, 14);
        check_val("p_ready",     t_ready_cyc, 15);
        check_val("p_safety",    t_viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/nfc_atom_ca_latch.md
Name: nfc_atom_ca_latch

Overview:
- Atomic command/address latch generator: drives the NAND pin-level CLE/ALE/WE#/DQ sequence for 1–5 command or address bytes.
- Sits directly downstream of the NFC command FSMs (reset, read, program, erase). Consumes bit 6 of their ACG command bus plus TargetWay/NumOfData/CASelect/CAData.
- Returns bit 6 of the ACG Ready and LastStep vectors.
- Outputs feed the NAND PHY pin registers.

Parameters:
- NumberOfWays, 4, number of CE# lines / ways.
- tCS_CYC, 3, cycles CE#/CLE/ALE are set up before the first WE# fall (range 1..15).
- tWP_CYC, 2, WE# low cycles per byte (1..15).
- tWH_CYC, 2, WE# high cycles per byte, with DQ held (1..15).
- tCH_CYC, 2, cycles CE#/CLE/ALE are held after the last WE# rise (1..15).

Ports:
- iSystemClock  in  1  system clock.
- iReset  in  1  asynchronous reset, active-high.
- iStart  in  1  request level (ACG command bit 6).
- oReady  out  1  idle/accepting (ACG Ready bit 6).
- oLastStep  out  1  one-cycle completion pulse (ACG LastStep bit 6).
- iTargetWay  in  NumberOfWays  CE# pattern, active-low per way.
- iNumOfData  in  16  byte count.
- iCASelect  in  1  1 = command cycle (CLE), 0 = address cycle (ALE).
- iCAData  in  40  bytes, first byte in [39:32], then [31:24], [23:16], [15:8], [7:0].
- oCE_n  out  NumberOfWays  chip enables.
- oCLE  out  1  command latch enable.
- oALE  out  1  address latch enable.
- oWE_n  out  1  write enable.
- oDQ  out  8  data bus.
- oDQOE  out  1  DQ output enable.

Behaviour:
- Reset values (asynchronous): oReady=1, oLastStep=0, oCE_n=all 1, oCLE=0, oALE=0, oWE_n=1, oDQ=0, oDQOE=0, state=IDLE.
- Clock, reset and port names follow the codebase: iSystemClock, iReset. The reset is asynchronous and active-high.
- All outputs are registered.
- Accept: in IDLE, at a rising edge with iStart=1 and oReady=1, latch:
  - iTargetWay, iCASelect and iCAData;
  - byte count N = min(iNumOfData, 5).
- oReady drops to 0 in the cycle after accept.
- iStart is level-held by the upstream; it is ignored whenever oReady=0.
- States:
  - IDLE: oReady=1, oCE_n all 1, oCLE/oALE/oDQOE low.
  - SETUP: tCS_CYC cycles. oCE_n=latched way; oCLE=CASelect; oALE=~CASelect; oDQOE=1; oDQ=current byte.
  - WE_LOW: tWP_CYC cycles, oWE_n=0.
  - WE_HIGH: tWH_CYC cycles, oWE_n=1, byte held. On exit, shift the data register left by 8 and decrement the remaining count. Go to WE_LOW if bytes remain, else HOLD.
  - HOLD: tCH_CYC cycles. CE#/CLE/ALE held, WE_n=1.
  - DONE: exactly 1 cycle. oLastStep=1, oReady=0, CE# released (all 1), CLE/ALE/DQOE=0. Then IDLE.
- N=0: SETUP → DONE directly. No WE# pulse, no CLE/ALE assertion, oLastStep still pulses once.
- N>5: clamped to 5; extra bytes are never emitted.
- Latency with defaults, N=1, accept at edge E0:
  - cycles 1–3 SETUP, 4–5 WE_LOW, 6–7 WE_HIGH, 8–9 HOLD;
  - cycle 10 oLastStep=1;
  - cycle 11 oReady=1.
- General: LastStep appears in cycle tCS_CYC + N·(tWP_CYC+tWH_CYC) + tCH_CYC + 1 after accept.
- oReady returns high one cycle after oLastStep. The upstream still holds iStart high during the LastStep cycle, so this ordering is mandatory to prevent re-trigger.
- Exactly one oLastStep pulse per accepted request.
- Timing counter: 4 bits, loaded with PARAM-1 on state entry, exit at 0.
- oWE_n never goes low unless CE# of the target way is low and exactly one of CLE/ALE is high.
- iTargetWay/iCAData changes after accept have no effect.
- Reset mid-operation: outputs return immediately to reset values; no oLastStep is produced; IDLE on release.

Test Plan:
- Reset command (TargetWay=4'b1110, N=1, CASelect=1, CAData=40'hFF_00000000) → oCE_n=1110 for cycles 1–9; oCLE=1; one WE# low pulse in cycles 4–5 with oDQ=8'hFF; oLastStep in cycle 10; oReady in cycle 11.
- 5-byte address (CASelect=0, CAData=40'h11_22_33_44_55, way 4'b0111) → oALE=1, oCLE=0; five WE# pulses with DQ 11,22,33,44,55 in order; oLastStep in cycle 3+20+2+1=26.
- N=0 → no WE# pulse, CLE/ALE stay 0, oLastStep in cycle 4, oReady in cycle 5.
- iStart held high continuously through completion → exactly one transaction, one oLastStep pulse; a second transaction starts only at the edge where oReady=1.
- iNumOfData=16'h0007 → exactly 5 WE# pulses.
- Assert iReset during the third byte → outputs immediately at reset values (oCE_n all 1, oWE_n=1, oReady=1); no oLastStep; a new request after release completes normally.
